// File: rtl/mdu_ex_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Runs a shift-add multiplier or a restoring divider on magnitudes latched at
// issue. The pipeline is held through STALL_MD until the result is ready.
module mdu_ex_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MD_REQ_EX,
    input  logic [2:0]      FUNCT3_EX,
    input  logic [XLEN-1:0] OPA_EX,
    input  logic [XLEN-1:0] OPB_EX,
    input  logic            FLUSH_EX,
    output logic            STALL_MD,
    output logic            MD_DONE_EX,
    output logic [XLEN-1:0] MD_RESULT_EX,
    output logic            BUSY_MD
);

    localparam int unsigned     CW        = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed;
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_by_zero, div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign STALL_MD     = MD_REQ_EX & ~FLUSH_EX & (state_q != DONE);
    assign MD_DONE_EX   = (state_q == DONE);
    assign BUSY_MD      = (state_q != IDLE);
    assign MD_RESULT_EX = result_q;

    // Issue-time operand decode plus one multiply / divide iteration and sign fix-up.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (FUNCT3_EX[2]) begin
            a_signed = ~FUNCT3_EX[0];
            b_signed = ~FUNCT3_EX[0];
        end else begin
            a_signed = (FUNCT3_EX[1:0] == 2'b01) || (FUNCT3_EX[1:0] == 2'b10);
            b_signed = (FUNCT3_EX[1:0] == 2'b01);
        end
        neg_a_in    = a_signed & OPA_EX[XLEN-1];
        neg_b_in    = b_signed & OPB_EX[XLEN-1];
        mag_a_in    = neg_a_in ? -OPA_EX : OPA_EX;
        mag_b_in    = neg_b_in ? -OPB_EX : OPB_EX;
        div_by_zero = FUNCT3_EX[2] && (OPB_EX == '0);
        div_ovf     = FUNCT3_EX[2] && !FUNCT3_EX[0] && (OPA_EX == MIN_NEG) && (OPB_EX == '1);

        // Multiplier: low half of acc holds the remaining multiplier bits.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        // Divider: acc is {remainder, quotient}; remainder gets an extra bit after the shift.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, mag_b_q};

        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (MD_REQ_EX && !FLUSH_EX) begin
                    funct3_d = FUNCT3_EX;
                    sign_a_d = neg_a_in;
                    sign_b_d = neg_b_in;
                    mag_a_d  = mag_a_in;
                    mag_b_d  = mag_b_in;
                    cnt_d    = '0;
                    acc_d    = FUNCT3_EX[2] ? {{XLEN{1'b0}}, mag_a_in}
                                            : {{XLEN{1'b0}}, mag_b_in};
                    if (div_by_zero) begin
                        result_d = FUNCT3_EX[1] ? OPA_EX : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = FUNCT3_EX[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (FLUSH_EX || !MD_REQ_EX) begin
                    state_d = IDLE;
                end else begin
                    if (funct3_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (FLUSH_EX || !MD_REQ_EX) begin
                    state_d = IDLE;
                end else begin
                    if (funct3_q[2]) begin
                        result_d = funct3_q[1] ? rem_fix : quo_fix;
                    end else begin
                        result_d = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                            : prod_fix[2*XLEN-1:XLEN];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_ex_sequencer.sv
// Self-checking bench for mdu_ex_sequencer: directed and random RV32M operations
// compared against an arithmetic reference model, plus stall, flush and reset behaviour.
module tb_mdu_ex_sequencer;

    logic        clk;
    logic        reset;
    logic        MD_REQ_EX;
    logic [2:0]  FUNCT3_EX;
    logic [31:0] OPA_EX;
    logic [31:0] OPB_EX;
    logic        FLUSH_EX;
    logic        STALL_MD;
    logic        MD_DONE_EX;
    logic [31:0] MD_RESULT_EX;
    logic        BUSY_MD;

    int checks = 0;
    int passes = 0;

    mdu_ex_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .MD_REQ_EX    (MD_REQ_EX),
        .FUNCT3_EX    (FUNCT3_EX),
        .OPA_EX       (OPA_EX),
        .OPB_EX       (OPB_EX),
        .FLUSH_EX     (FLUSH_EX),
        .STALL_MD     (STALL_MD),
        .MD_DONE_EX   (MD_DONE_EX),
        .MD_RESULT_EX (MD_RESULT_EX),
        .BUSY_MD      (BUSY_MD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics from 64-bit / signed integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * ub;  r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Expected cycle of MD_DONE_EX counted from the request cycle.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if (f3 == 3'd4 || f3 == 3'd6) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        end
        return 34;
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request and observe it until MD_DONE_EX (bounded).
    // mode 0: operands held; 1: operands zeroed at cycle 3; 2: operands scrambled every stalled cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int mode, output logic [31:0] res, output int lat,
                          output bit stall_ok);
        stall_ok = 1'b1;
        lat      = -1;
        res      = '0;
        @(posedge clk); #1;
        MD_REQ_EX = 1'b1;
        FLUSH_EX  = 1'b0;
        FUNCT3_EX = f3;
        OPA_EX    = a;
        OPB_EX    = b;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (mode == 1 && c == 3) begin
                    OPA_EX = '0;
                    OPB_EX = '0;
                end
                if (mode == 2) begin
                    OPA_EX = $urandom;
                    OPB_EX = $urandom;
                end
            end
            @(negedge clk);
            if (MD_DONE_EX === 1'b1) begin
                lat = c;
                res = MD_RESULT_EX;
                if (STALL_MD !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (STALL_MD !== 1'b1) stall_ok = 1'b0;
            if (c == 0 && BUSY_MD !== 1'b0) stall_ok = 1'b0;
            if (c > 0 && BUSY_MD !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MD_REQ_EX = 1'b0;
        FLUSH_EX  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        MD_REQ_EX = 1'b1;
        FUNCT3_EX = 3'd0;
        OPA_EX    = 32'd3;
        OPB_EX    = 32'd4;
        FLUSH_EX  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (BUSY_MD !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY_MD);
        else passes++;
        checks++;
        if (MD_DONE_EX !== 1'b0) $display("FAIL reset_done: got %b expected 0", MD_DONE_EX);
        else passes++;
        checks++;
        if (MD_RESULT_EX !== 32'd0) $display("FAIL reset_result: got %h expected 0", MD_RESULT_EX);
        else passes++;
        MD_REQ_EX = 1'b0;
        #1;
        checks++;
        if (STALL_MD !== 1'b0) $display("FAIL reset_stall: got %b expected 0", STALL_MD);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
        logic [31:0] as  [14] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd9};
        logic [31:0] bs  [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] res;
        int          lat;
        bit          sok;
        for (int i = 0; i < 14; i++) begin
            run_op(f3s[i], as[i], bs[i], 0, res, lat, sok);
            checks++;
            if (res !== ref_md(f3s[i], as[i], bs[i]))
                $display("FAIL dir_result[%0d] f3=%0d: got %h expected %h", i, f3s[i], res,
                         ref_md(f3s[i], as[i], bs[i]));
            else passes++;
            checks++;
            if (lat !== ref_lat(f3s[i], as[i], bs[i]))
                $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat,
                         ref_lat(f3s[i], as[i], bs[i]));
            else passes++;
            checks++;
            if (sok !== 1'b1) $display("FAIL dir_stall[%0d]: got %b expected 1", i, sok);
            else passes++;
            go_idle();
        end
    endtask

    task automatic test_operand_latch();
        logic [31:0] res;
        int          lat;
        bit          sok;
        run_op(3'd0, 32'd6, 32'd9, 1, res, lat, sok);
        checks++;
        if (res !== ref_md(3'd0, 32'd6, 32'd9))
            $display("FAIL latch_result: got %h expected %h", res, ref_md(3'd0, 32'd6, 32'd9));
        else passes++;
        checks++;
        if (lat !== 34) $display("FAIL latch_latency: got %0d expected 34", lat);
        else passes++;
    endtask

    // Called right after test_operand_latch so the second request lands in the cycle after DONE.
    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          sok;
        run_op(3'd0, 32'd12345, 32'hFFFFFFB3, 0, res, lat, sok);
        checks++;
        if (res !== ref_md(3'd0, 32'd12345, 32'hFFFFFFB3))
            $display("FAIL b2b_result: got %h expected %h", res,
                     ref_md(3'd0, 32'd12345, 32'hFFFFFFB3));
        else passes++;
        checks++;
        if (lat !== 34) $display("FAIL b2b_latency: got %0d expected 34", lat);
        else passes++;
        checks++;
        if (sok !== 1'b1) $display("FAIL b2b_stall: got %b expected 1", sok);
        else passes++;
        go_idle();
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        int          lat;
        bit          sok;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_op();
            b  = pick_op();
            run_op(f3, a, b, 2, res, lat, sok);
            checks++;
            if (res !== ref_md(f3, a, b))
                $display("FAIL rnd_result[%0d] f3=%0d a=%h b=%h: got %h expected %h",
                         i, f3, a, b, res, ref_md(f3, a, b));
            else passes++;
            checks++;
            if (lat !== ref_lat(f3, a, b))
                $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, ref_lat(f3, a, b));
            else passes++;
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
    endtask

    task automatic test_flush();
        bit seen_done;
        @(posedge clk); #1;
        MD_REQ_EX = 1'b1;
        FLUSH_EX  = 1'b0;
        FUNCT3_EX = 3'd4;
        OPA_EX    = 32'd1000;
        OPB_EX    = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        FLUSH_EX = 1'b1;
        @(negedge clk);
        checks++;
        if (STALL_MD !== 1'b0) $display("FAIL flush_stall: got %b expected 0", STALL_MD);
        else passes++;
        checks++;
        if (BUSY_MD !== 1'b1) $display("FAIL flush_busy_before: got %b expected 1", BUSY_MD);
        else passes++;
        @(posedge clk); #1;
        FLUSH_EX  = 1'b0;
        MD_REQ_EX = 1'b0;
        @(negedge clk);
        checks++;
        if (BUSY_MD !== 1'b0) $display("FAIL flush_idle: got %b expected 0", BUSY_MD);
        else passes++;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MD_DONE_EX !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", seen_done);
        else passes++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        MD_REQ_EX = 1'b1;
        FUNCT3_EX = 3'd0;
        OPA_EX    = 32'd6;
        OPB_EX    = 32'd9;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (BUSY_MD !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", BUSY_MD);
        else passes++;
        @(posedge clk); #1;
        reset     = 1'b1;
        MD_REQ_EX = 1'b0;
        @(negedge clk);
        checks++;
        if (BUSY_MD !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", BUSY_MD);
        else passes++;
        checks++;
        if (MD_RESULT_EX !== 32'd0) $display("FAIL rstmid_result: got %h expected 0", MD_RESULT_EX);
        else passes++;
        checks++;
        if (MD_DONE_EX !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", MD_DONE_EX);
        else passes++;
    endtask

    initial begin
        reset     = 1'b0;
        MD_REQ_EX = 1'b0;
        FUNCT3_EX = '0;
        OPA_EX    = '0;
        OPB_EX    = '0;
        FLUSH_EX  = 1'b0;
        test_reset();
        test_directed();
        test_operand_latch();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
